// File: rtl/field_edit_ctrl.sv
// Time-field edit controller: loads hh/mm/ss in BCD, edits them from keypad pulses, commits via req/ack.
// Optional idle auto-exit is compiled in when EDIT_TIMEOUT_EN is defined.
module field_edit_ctrl
`ifdef EDIT_TIMEOUT_EN
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000_000
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_configurate,
    input  logic       i_clock_timer,
    input  logic       i_T24_12,
    input  logic       i_arriba,
    input  logic       i_abajo,
    input  logic       i_izquierda,
    input  logic       i_derecha,
    input  logic       i_write,
    input  logic [7:0] i_cur_hh,
    input  logic [7:0] i_cur_mm,
    input  logic [7:0] i_cur_ss,
    input  logic       i_wr_ack,
    output logic       o_edit_active,
    output logic [1:0] o_cursor,
    output logic [7:0] o_edit_hh,
    output logic [7:0] o_edit_mm,
    output logic [7:0] o_edit_ss,
    output logic       o_wr_req,
    output logic       o_wr_bank,
    output logic       o_commit_done
`ifdef EDIT_TIMEOUT_EN
    ,
    output logic       o_edit_timeout
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, EDIT, COMMIT} state_t;

    state_t     r_state, w_nextState;
    logic       r_cfgQ, r_writeQ, r_t24Q;
    logic [1:0] r_cursor;
    logic [7:0] r_editHh, r_editMm, r_editSs;
    logic       r_wrReq, r_wrBank, r_commitDone;
    logic       w_cfgRise, w_cfgFall, w_writeTog, w_t24Rise, w_ackTaken;
    logic [7:0] w_hhLo, w_hhHi;

    function automatic logic bcdOk(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] bcdInc(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        if (v == hi)             return lo;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'h0};
        else                     return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcdDec(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        if (v == lo)             return hi;
        else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'h9};
        else                     return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] clampMs(input logic [7:0] v);
        return (bcdOk(v) && v <= 8'h59) ? v : 8'h00;
    endfunction

    function automatic logic [7:0] clampHh(input logic [7:0] v, input logic mode12);
        if (mode12) return (bcdOk(v) && v >= 8'h01 && v <= 8'h12) ? v : 8'h12;
        else        return (bcdOk(v) && v <= 8'h23) ? v : 8'h00;
    endfunction

    // 24 h -> 12 h hour mapping; results stay below 20, so adding 6 converts binary 10/11 to BCD.
    function automatic logic [7:0] map12(input logic [7:0] v);
        logic [7:0] b;
        b = ({4'd0, v[7:4]} * 8'd10) + {4'd0, v[3:0]};
        if (b == 8'd0)  return 8'h12;
        if (b <= 8'd12) return v;
        b = b - 8'd12;
        return (b >= 8'd10) ? (b + 8'd6) : b;
    endfunction

    assign w_cfgRise  = i_configurate & ~r_cfgQ;
    assign w_cfgFall  = ~i_configurate & r_cfgQ;
    assign w_writeTog = i_write ^ r_writeQ;
    assign w_t24Rise  = i_T24_12 & ~r_t24Q;
    assign w_ackTaken = r_wrReq & i_wr_ack;
    assign w_hhLo     = r_t24Q ? 8'h01 : 8'h00;
    assign w_hhHi     = r_t24Q ? 8'h12 : 8'h23;

`ifdef EDIT_TIMEOUT_EN
    logic [31:0] r_idleCnt;
    logic        r_editTimeout;
    logic        w_anyKey, w_timeoutHit;
    assign w_anyKey     = i_arriba | i_abajo | i_izquierda | i_derecha | w_writeTog;
    assign w_timeoutHit = (r_idleCnt == TIMEOUT_CYCLES - 32'd1) && !w_anyKey;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_cfgRise) w_nextState = LOAD;
            LOAD:    w_nextState = EDIT;
            EDIT: begin
                if (w_cfgFall)       w_nextState = IDLE;
                else if (w_writeTog) w_nextState = COMMIT;
`ifdef EDIT_TIMEOUT_EN
                else if (w_timeoutHit) w_nextState = IDLE;
`endif
            end
            COMMIT:  if (w_ackTaken) w_nextState = i_configurate ? EDIT : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        o_edit_active = (r_state != IDLE);
        o_cursor      = r_cursor;
        o_edit_hh     = r_editHh;
        o_edit_mm     = r_editMm;
        o_edit_ss     = r_editSs;
        o_wr_req      = r_wrReq;
        o_wr_bank     = r_wrBank;
        o_commit_done = r_commitDone;
`ifdef EDIT_TIMEOUT_EN
        o_edit_timeout = r_editTimeout;
`endif
    end

    // Edit datapath: edge-detect copies run in every state; edits only move in EDIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cfgQ       <= 1'b0;
            r_writeQ     <= 1'b0;
            r_t24Q       <= 1'b0;
            r_cursor     <= 2'd0;
            r_editHh     <= 8'h00;
            r_editMm     <= 8'h00;
            r_editSs     <= 8'h00;
            r_wrReq      <= 1'b0;
            r_wrBank     <= 1'b0;
            r_commitDone <= 1'b0;
`ifdef EDIT_TIMEOUT_EN
            r_idleCnt     <= 32'd0;
            r_editTimeout <= 1'b0;
`endif
        end else begin
            r_cfgQ       <= i_configurate;
            r_writeQ     <= i_write;
            r_t24Q       <= i_T24_12;
            r_commitDone <= 1'b0;
`ifdef EDIT_TIMEOUT_EN
            r_editTimeout <= 1'b0;
`endif
            case (r_state)
                LOAD: begin
                    r_editHh <= clampHh(i_cur_hh, i_T24_12);
                    r_editMm <= clampMs(i_cur_mm);
                    r_editSs <= clampMs(i_cur_ss);
                    r_wrBank <= i_clock_timer;
                    r_cursor <= 2'd0;
`ifdef EDIT_TIMEOUT_EN
                    r_idleCnt <= 32'd0;
`endif
                end
                EDIT: begin
                    if (!w_cfgFall && !w_writeTog) begin
                        if (w_t24Rise) begin
                            r_editHh <= map12(r_editHh);
                        end else if (i_arriba) begin
                            case (r_cursor)
                                2'd0:    r_editHh <= bcdInc(r_editHh, w_hhLo, w_hhHi);
                                2'd1:    r_editMm <= bcdInc(r_editMm, 8'h00, 8'h59);
                                default: r_editSs <= bcdInc(r_editSs, 8'h00, 8'h59);
                            endcase
                        end else if (i_abajo) begin
                            case (r_cursor)
                                2'd0:    r_editHh <= bcdDec(r_editHh, w_hhLo, w_hhHi);
                                2'd1:    r_editMm <= bcdDec(r_editMm, 8'h00, 8'h59);
                                default: r_editSs <= bcdDec(r_editSs, 8'h00, 8'h59);
                            endcase
                        end else if (i_izquierda) begin
                            r_cursor <= (r_cursor == 2'd0) ? 2'd2 : r_cursor - 2'd1;
                        end else if (i_derecha) begin
                            r_cursor <= (r_cursor >= 2'd2) ? 2'd0 : r_cursor + 2'd1;
                        end
                    end
`ifdef EDIT_TIMEOUT_EN
                    if (w_anyKey)          r_idleCnt <= 32'd0;
                    else if (w_timeoutHit) r_idleCnt <= 32'd0;
                    else                   r_idleCnt <= r_idleCnt + 32'd1;
                    r_editTimeout <= w_timeoutHit && !w_cfgFall;
`endif
                end
                COMMIT: begin
                    if (w_ackTaken) begin
                        r_wrReq      <= 1'b0;
                        r_commitDone <= 1'b1;
                    end else begin
                        r_wrReq <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
